// File: rtl/gpio_uart_tx.sv
// Byte-oriented 8N1 UART transmitter fed by a small FIFO; frames are sent back to back.
// Optional even parity bit when UART_TX_PARITY_EN is defined (8E1, 11-bit frames).
module gpio_uart_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int BW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            wr_ready_q, wr_ready_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  logic push;
  logic pop;
  logic bit_end;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    pop      = 1'b0;
    bit_end  = (baud_q == BW'(DIV - 1));

    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) pop = 1'b1;
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Pop straight from the stop bit so queued frames follow with no idle cycle.
        if (bit_end) begin
          if (count_q != '0) pop = 1'b1;
          else               state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      state_d = S_START;
      shift_d = mem_q[rd_ptr_q];
      bit_d   = '0;
      baud_d  = '0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^mem_q[rd_ptr_q];
`endif
    end

    push       = wr_valid && wr_ready_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    // Registered from the next count, so a full FIFO never sees an extra write.
    wr_ready_d = (count_d < CW'(FIFO_DEPTH));

    case (state_d)
      S_START:   txd_d = 1'b0;
      S_DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY:  txd_d = par_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      wr_ready_q <= 1'b1;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
      wr_ready_q <= wr_ready_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Storage needs no reset; emptiness is tracked by count and pointers.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign txd        = txd_q;
  assign wr_ready   = wr_ready_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_gpio_uart_tx.sv
// Bench for gpio_uart_tx: DIV=10, 4-entry FIFO, cycle model of the line plus a line decoder.
module tb_gpio_uart_tx;
  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int DEPTH  = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       txd;
  logic       busy;
  logic [2:0] fifo_count;

  gpio_uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .txd       (txd),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of waiting bytes plus the frame on the line and its elapsed cycles.
  logic [7:0] m_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_pos;

  // Line decoder state
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  bit         rx_active;
  int         rx_c;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;  // line bits in time order, bit 0 first
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic exp_txd();
    int k;
    if (!m_active) return 1'b1;
    k = m_pos / DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_active  = 0;
    m_pos     = 0;
    rx_active = 0;
    rx_c      = 0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d);
    bit pre_ready;
    pre_ready = (m_q.size() < DEPTH);
    if (m_active) begin
      m_pos++;
      if (m_pos == NB * DIV) m_active = 0;
    end
    if (!m_active && m_q.size() != 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_pos    = 0;
    end
    if (v && pre_ready) begin
      m_q.push_back(d);
      acc_log.push_back(d);
    end
  endtask

  task automatic rx_sample();
    int rb;
    if (!rx_active) begin
      if (txd === 1'b0) begin
        rx_active = 1;
        rx_c      = 0;
      end
    end else begin
      rx_c++;
    end
    if (rx_active && (rx_c % DIV == DIV / 2)) begin
      rb = rx_c / DIV;
      if (rb >= 1 && rb <= 8) rx_byte[rb-1] = txd;
`ifdef UART_TX_PARITY_EN
      if (rb == 9) chk("parity_bit", {31'd0, txd}, {31'd0, ^rx_byte});
`endif
      if (rb == NB - 1) begin
        chk("stop_bit", {31'd0, txd}, 32'd1);
        rx_q.push_back(rx_byte);
        rx_active = 0;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then compare every output with the model.
  task automatic tick(input logic v, input logic [7:0] d);
    logic [5:0] exp_v;
    logic [5:0] act_v;
    wr_valid = v;
    wr_data  = d;
    @(posedge CLOCK_50);
    model_edge(v, d);
    #1;
    exp_v = {exp_txd(), (m_active || m_q.size() != 0), (m_q.size() < DEPTH), 3'(m_q.size())};
    act_v = {txd, busy, wr_ready, fifo_count};
    chk("cycle{txd,busy,ready,count}", {26'd0, act_v}, {26'd0, exp_v});
    rx_sample();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || rx_active) && n < budget) begin
      tick(1'b0, 8'h00);
      n++;
    end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[6];
    bit         v;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 11'b10101001010};
    vecs[1] = '{8'h07, 11'b11000001110};
    vecs[2] = '{8'h00, 11'b10000000000};
    vecs[3] = '{8'hFF, 11'b10111111110};
`else
    vecs[0] = '{8'hA5, 11'b01101001010};
    vecs[1] = '{8'h07, 11'b01000001110};
    vecs[2] = '{8'h00, 11'b01000000000};
    vecs[3] = '{8'hFF, 11'b01111111110};
`endif

    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fifo_count", {29'd0, fifo_count}, 32'd0);
    #2 reset = 1'b0;

    // Single frames: exact bit pattern and busy fall time.
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, vecs[i].data);
      tick(1'b0, 8'h00);  // pop edge, start bit begins
      for (int c = 0; c < NB * DIV; c++) begin
        if (c % DIV == DIV / 2) chk("frame_bit", {31'd0, txd}, {31'd0, vecs[i].frame[c / DIV]});
        if (c == NB * DIV - 1) chk("busy_before_end", {31'd0, busy}, 32'd1);
        tick(1'b0, 8'h00);
      end
      chk("busy_at_end", {31'd0, busy}, 32'd0);
      $display("frame 0x%02h done, decoded 0x%02h", vecs[i].data, rx_q.size() > 0 ? rx_q[rx_q.size()-1] : 8'hxx);
    end
    wait_idle(50);

    // Back-to-back: 0x00 then 0xFF on consecutive cycles.
    rx_q.delete();
    tick(1'b1, 8'h00);
    tick(1'b1, 8'hFF);
    for (int c = 0; c < 2 * NB * DIV; c++) begin
      if (c == NB * DIV - 1) chk("b2b_stop", {31'd0, txd}, 32'd1);
      if (c == NB * DIV) begin
        chk("b2b_second_start", {31'd0, txd}, 32'd0);
        chk("b2b_count", {29'd0, fifo_count}, 32'd0);
      end
      tick(1'b0, 8'h00);
    end
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);
    wait_idle(50);
    chk("b2b_rx_n", rx_q.size(), 32'd2);
    if (rx_q.size() == 2) begin
      chk("b2b_rx0", {24'd0, rx_q[0]}, 32'h00);
      chk("b2b_rx1", {24'd0, rx_q[1]}, 32'hFF);
    end
    $display("back-to-back 0x00,0xFF: %0d bytes decoded", rx_q.size());

    // Fill the FIFO behind a frame in progress: sixth write is dropped.
    rx_q.delete();
    for (int i = 0; i < 6; i++) bq[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) tick(1'b1, bq[i]);
    chk("full_count", {29'd0, fifo_count}, 32'd4);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    wait_idle(NB * DIV * 6 + 20);
    chk("drain_count", {29'd0, fifo_count}, 32'd0);
    chk("full_rx_n", rx_q.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < rx_q.size()) chk("full_rx_byte", {24'd0, rx_q[i]}, {24'd0, bq[i]});
    $display("fifo full test: %0d bytes decoded", rx_q.size());

    // Write on the same edge as a pop with two bytes queued.
    rx_q.delete();
    for (int i = 0; i < 4; i++) bq[i] = 8'($urandom);
    tick(1'b1, bq[0]);
    tick(1'b1, bq[1]);
    tick(1'b1, bq[2]);
    chk("wp_pre_count", {29'd0, fifo_count}, 32'd2);
    repeat (NB * DIV - 2) tick(1'b0, 8'h00);
    tick(1'b1, bq[3]);
    chk("wp_count", {29'd0, fifo_count}, 32'd2);
    chk("wp_txd_start", {31'd0, txd}, 32'd0);
    wait_idle(NB * DIV * 5 + 20);
    chk("wp_rx_n", rx_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < rx_q.size()) chk("wp_rx_byte", {24'd0, rx_q[i]}, {24'd0, bq[i]});
    $display("write+pop test: %0d bytes decoded", rx_q.size());

    // Random traffic, sparse then dense.
    rx_q.delete();
    acc_log.delete();
    for (int i = 0; i < 4000; i++) begin
      v = ($urandom_range(0, 99) < ((i < 2000) ? 1 : 60));
      tick(v, 8'($urandom));
    end
    wait_idle(NB * DIV * (DEPTH + 2));
    chk("rand_rx_n", rx_q.size(), acc_log.size());
    for (int i = 0; i < acc_log.size(); i++)
      if (i < rx_q.size()) chk("rand_rx_byte", {24'd0, rx_q[i]}, {24'd0, acc_log[i]});
    $display("random traffic: %0d accepted, %0d decoded", acc_log.size(), rx_q.size());

    // Asynchronous reset in the middle of a frame.
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h81);
    repeat (40) tick(1'b0, 8'h00);
    chk("pre_reset_txd", {31'd0, txd}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("arst_txd", {31'd0, txd}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_count", {29'd0, fifo_count}, 32'd0);
    chk("arst_wr_ready", {31'd0, wr_ready}, 32'd1);
    model_reset();
    rx_q.delete();
    @(posedge CLOCK_50);
    #3 reset = 1'b0;
    repeat (3 * NB * DIV) tick(1'b0, 8'h00);
    chk("no_tx_after_reset", rx_q.size(), 32'd0);
    $display("mid-frame reset: %0d bytes after release", rx_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
